pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Sequencing controller for pipeline stalls and flushes in the 5-stage MIPS core. It takes the load-use detect, the branch decode in ID, the branch outcome in EX and the multi-cycle mul/div issue. It drives the PC hold, IF/ID hold/flush and ID/EX bubble controls from one state machine, and keeps a saturating stall-cycle counter for performance measurement. It sits between the ID-stage decode and the PC, IF/ID and ID/EX-control-mux registers.

## Interface
- `MULDIV_CYCLES`, 4: execute latency of the mul/div unit in cycles; legal range 1..15.
- `STALL_CNT_W`, 16: width of the stall-cycle counter.

- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `LoadUse`  in  1  ID/EX holds a lw whose Rt matches an operand of the instruction in IF/ID.
- `IDBranch`  in  1  instruction in IF/ID decodes as beq/bne.
- `BranchTaken`  in  1  branch in EX resolved taken; sampled only in state BR_EX.
- `MulDivStart`  in  1  instruction in IF/ID is mult/div.
- `StallClr`  in  1  synchronous clear of `StallCycles`.
- `PCwrite`  out  1  1 = hold PC this cycle.
- `PCsrc`  out  1  1 = PC loads the branch target.
- `IFIDwrite`  out  1  1 = hold the IF/ID register.
- `IFIDflush`  out  1  1 = IF/ID loads a nop.
- `controlmux`  out  1  1 = zero the control word entering ID/EX (bubble).
- `MulDivGo`  out  1  one-cycle start pulse to the mul/div unit.
- `MulDivBusy`  out  1  mul/div in progress.
- `StallCycles`  out  STALL_CNT_W  count of cycles with `PCwrite`=1, saturating.

## Operation
- States: RUN, BR_EX, MD_BUSY. Reset state is RUN. The mul/div down-counter `mdcnt` (4 bits) resets to 0. `StallCycles` resets to 0.
- All control outputs are combinational from the state and the inputs. In RUN with all inputs 0, every output is 0.
- RUN uses this priority, evaluated each cycle:
  - `LoadUse`: `PCwrite`=1, `IFIDwrite`=1, `controlmux`=1. State stays RUN, giving one bubble. A branch or mul/div in ID is re-evaluated next cycle.
  - `IDBranch`: `PCwrite`=1, `IFIDflush`=1, `controlmux`=0 so the branch advances to EX. Next state is BR_EX.
  - `MulDivStart`: `MulDivGo`=1 and there is no stall, so the mul/div advances to EX. `mdcnt` is loaded with MULDIV_CYCLES-1. Next state is MD_BUSY.
  - Otherwise all outputs are 0.
- BR_EX: `controlmux`=1, `PCwrite`=0, `PCsrc`=`BranchTaken`, `IFIDflush`=`BranchTaken`. Next state is always RUN.
  - Not taken: the fetch at PC+4 proceeds normally.
  - Taken: the wrong-path fetch is discarded.
- MD_BUSY: `PCwrite`=1, `IFIDwrite`=1, `controlmux`=1, `MulDivBusy`=1.
  - When `mdcnt`=0, next state is RUN.
  - Otherwise `mdcnt` decrements.
- `LoadUse`, `IDBranch` and `MulDivStart` are ignored in BR_EX and MD_BUSY.
- `IFIDflush` takes precedence over `IFIDwrite`. The FSM never asserts both.
- `StallCycles`:
  - Increments on each edge where `PCwrite`=1.
  - Holds at all-ones once saturated.
  - `StallClr` has priority over the increment: a clear and a stall in the same cycle leave the counter at 0.

## Timing
- Load-use penalty is 1 cycle, with the bubble inserted in the same cycle `LoadUse` is seen.
- Branch penalty is 1 cycle, with the branch in EX exactly one cycle after `IDBranch` is accepted. A taken branch redirects on the BR_EX edge.
- Mul/div: `MulDivGo` is high for exactly one cycle, then MD_BUSY lasts exactly MULDIV_CYCLES cycles. Fetch resumes on the cycle after the last busy cycle.
- Reset asserted mid-operation returns the block immediately to RUN, with `mdcnt`=0 and `StallCycles`=0, and all outputs go to 0 while the inputs are 0. There is no pending branch or mul/div after reset.
- Back-to-back events: an `IDBranch` present on the RUN cycle after BR_EX or MD_BUSY is accepted on that cycle.

## Test plan
- Reset with all inputs 0 -> all outputs 0 and `StallCycles`=0. Drop `rst_n` in MD_BUSY -> RUN on the same edge, `MulDivBusy`=0.
- `LoadUse`=1 for one cycle in RUN -> that cycle `PCwrite`=`IFIDwrite`=`controlmux`=1 and `StallCycles` becomes 1. The next cycle all outputs are 0.
- `IDBranch`=1, then `BranchTaken`=1 next cycle:
  - Cycle 1: `PCwrite`=1, `IFIDflush`=1, `controlmux`=0.
  - Cycle 2: `PCsrc`=1, `IFIDflush`=1, `controlmux`=1, `PCwrite`=0.
  - Repeat with `BranchTaken`=0: cycle 2 has `PCsrc`=0, `IFIDflush`=0.
- `MulDivStart`=1 with MULDIV_CYCLES=4 -> `MulDivGo` is high for 1 cycle, then `MulDivBusy`/`PCwrite`=1 for exactly 4 cycles. `StallCycles` increases by 4.
- `LoadUse`=`IDBranch`=`MulDivStart`=1 together in RUN -> load-use bubble only. With `LoadUse` dropped next cycle, the branch is accepted and `MulDivGo` stays 0.
- `STALL_CNT_W`=4, stall for 20 cycles -> counter saturates at 15. `StallClr`=1 together with `PCwrite`=1 -> 0 next edge.

Source files
------------

// File: rtl/pipe_stall_if.sv
// ============================================================================
// pipe_stall_if : hazard inputs and stall/flush controls of pipe_stall_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipe_stall_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   LoadUse;
  logic                   IDBranch;
  logic                   BranchTaken;
  logic                   MulDivStart;
  logic                   StallClr;
  logic                   PCwrite;
  logic                   PCsrc;
  logic                   IFIDwrite;
  logic                   IFIDflush;
  logic                   controlmux;
  logic                   MulDivGo;
  logic                   MulDivBusy;
  logic [STALL_CNT_W-1:0] StallCycles;

  modport master (
    output LoadUse, IDBranch, BranchTaken, MulDivStart, StallClr,
    input  PCwrite, PCsrc, IFIDwrite, IFIDflush, controlmux,
    input  MulDivGo, MulDivBusy, StallCycles
  );

  modport slave (
    input  LoadUse, IDBranch, BranchTaken, MulDivStart, StallClr,
    output PCwrite, PCsrc, IFIDwrite, IFIDflush, controlmux,
    output MulDivGo, MulDivBusy, StallCycles
  );
endinterface

`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
// pipe_stall_ctrl : PC / IF-ID / ID-EX stall and flush sequencer with
//                   saturating stall-cycle counter
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_stall_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int STALL_CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_stall_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_EX   = 2'd1,
    MD_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] c_md_load = 4'(MULDIV_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [3:0]             r_mdcnt;
  logic [3:0]             w_mdcnt_nxt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic w_pcwrite;
  logic w_pcsrc;
  logic w_ifidwrite;
  logic w_ifidflush;
  logic w_controlmux;
  logic w_muldivgo;
  logic w_muldivbusy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_mdcnt <= 4'd0;
    end else begin
      r_state <= w_next;
      r_mdcnt <= w_mdcnt_nxt;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_mdcnt_nxt  = r_mdcnt;
    w_pcwrite    = 1'b0;
    w_pcsrc      = 1'b0;
    w_ifidwrite  = 1'b0;
    w_ifidflush  = 1'b0;
    w_controlmux = 1'b0;
    w_muldivgo   = 1'b0;
    w_muldivbusy = 1'b0;
    case (r_state)
      RUN: begin
        // Load-use wins; a branch or mul/div behind it is retried next cycle.
        if (bus.LoadUse) begin
          w_pcwrite    = 1'b1;
          w_ifidwrite  = 1'b1;
          w_controlmux = 1'b1;
        end else if (bus.IDBranch) begin
          w_pcwrite   = 1'b1;
          w_ifidflush = 1'b1;
          w_next      = BR_EX;
        end else if (bus.MulDivStart) begin
          w_muldivgo  = 1'b1;
          w_mdcnt_nxt = c_md_load;
          w_next      = MD_BUSY;
        end
      end
      BR_EX: begin
        w_controlmux = 1'b1;
        w_pcsrc      = bus.BranchTaken;
        w_ifidflush  = bus.BranchTaken;
        w_next       = RUN;
      end
      MD_BUSY: begin
        w_pcwrite    = 1'b1;
        w_ifidwrite  = 1'b1;
        w_controlmux = 1'b1;
        w_muldivbusy = 1'b1;
        if (r_mdcnt == 4'd0) begin
          w_next = RUN;
        end else begin
          w_mdcnt_nxt = r_mdcnt - 4'd1;
        end
      end
      default: begin
        w_next      = RUN;
        w_mdcnt_nxt = 4'd0;
      end
    endcase
  end

  // Clear beats increment; saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (bus.StallClr) begin
      r_stall_cnt <= '0;
    end else if (w_pcwrite && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.PCwrite     = w_pcwrite;
  assign bus.PCsrc       = w_pcsrc;
  assign bus.IFIDwrite   = w_ifidwrite;
  assign bus.IFIDflush   = w_ifidflush;
  assign bus.controlmux  = w_controlmux;
  assign bus.MulDivGo    = w_muldivgo;
  assign bus.MulDivBusy  = w_muldivbusy;
  assign bus.StallCycles = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// Directed scoreboard bench for pipe_stall_ctrl (MULDIV_CYCLES=4, 4-bit counter).
`default_nettype none

module tb_pipe_stall_ctrl;

  logic clk;
  logic rst_n;

  pipe_stall_if #(.STALL_CNT_W(4)) bus ();

  pipe_stall_ctrl #(
    .MULDIV_CYCLES(4),
    .STALL_CNT_W  (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl bit order: PCwrite PCsrc IFIDwrite IFIDflush controlmux MulDivGo MulDivBusy
  typedef struct {
    string      name;
    logic [6:0] ctl;
    logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [6:0] IDLE = 7'b0000000;
  localparam logic [6:0] LUB  = 7'b1010100;
  localparam logic [6:0] BRID = 7'b1001000;
  localparam logic [6:0] BRT  = 7'b0101100;
  localparam logic [6:0] BRN  = 7'b0000100;
  localparam logic [6:0] GO   = 7'b0000010;
  localparam logic [6:0] BUSY = 7'b1010101;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = q.pop_front();
      act = {bus.PCwrite, bus.PCsrc, bus.IFIDwrite, bus.IFIDflush,
             bus.controlmux, bus.MulDivGo, bus.MulDivBusy};
      n_checks++;
      if (act !== e.ctl) begin
        n_errors++;
        $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
      end
      n_checks++;
      if (bus.StallCycles !== e.cnt) begin
        n_errors++;
        $display("FAIL %s StallCycles: got %0d expected %0d", e.name, bus.StallCycles, e.cnt);
      end
    end
  end

  task automatic step(input logic lu, input logic br, input logic bt, input logic md,
                      input logic clr, input logic [6:0] ctl, input logic [3:0] cnt,
                      input string name);
    exp_t e;
    @(posedge clk);
    #1;
    bus.LoadUse     = lu;
    bus.IDBranch    = br;
    bus.BranchTaken = bt;
    bus.MulDivStart = md;
    bus.StallClr    = clr;
    e.name = name;
    e.ctl  = ctl;
    e.cnt  = cnt;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    rst_n           = 1'b0;
    bus.LoadUse     = 1'b0;
    bus.IDBranch    = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.MulDivStart = 1'b0;
    bus.StallClr    = 1'b0;

    step(0,0,0,0,0, IDLE, 4'd0, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    step(0,0,0,0,0, IDLE, 4'd0, "idle");
    step(1,0,0,0,0, LUB,  4'd0, "loaduse");
    step(0,0,0,0,0, IDLE, 4'd1, "after_lu");
    step(0,1,0,0,0, BRID, 4'd1, "br_id_t");
    step(0,0,1,0,0, BRT,  4'd2, "br_ex_taken");
    step(0,1,0,0,0, BRID, 4'd2, "br_id_nt");
    step(0,0,0,0,0, BRN,  4'd3, "br_ex_nt");
    step(0,0,0,1,0, GO,   4'd3, "md_go");
    step(0,0,0,0,0, BUSY, 4'd3, "md_busy1");
    step(0,0,0,0,0, BUSY, 4'd4, "md_busy2");
    step(0,0,0,0,0, BUSY, 4'd5, "md_busy3");
    step(0,0,0,0,0, BUSY, 4'd6, "md_busy4");
    step(0,0,0,0,0, IDLE, 4'd7, "md_done");
    step(1,1,0,1,0, LUB,  4'd7, "all_three");
    step(0,1,0,1,0, BRID, 4'd8, "br_over_md");
    step(1,0,0,1,0, BRN,  4'd9, "brex_ignores");
    step(0,1,0,0,0, BRID, 4'd9, "br_after_brex");
    step(0,1,1,0,0, BRT,  4'd10, "brex_taken2");
    step(0,0,0,0,0, IDLE, 4'd10, "idle2");
    step(0,0,0,1,0, GO,   4'd10, "md_go2");
    step(1,1,0,1,0, BUSY, 4'd10, "md_ignores1");
    step(0,1,0,0,0, BUSY, 4'd11, "md_ignores2");
    step(0,1,0,0,0, BUSY, 4'd12, "md_ignores3");
    step(0,1,0,0,0, BUSY, 4'd13, "md_ignores4");
    step(0,1,0,0,0, BRID, 4'd14, "br_after_md");
    step(0,0,0,0,0, BRN,  4'd15, "brex_nt3");
    step(1,0,0,0,0, LUB,  4'd15, "lu_sat");
    step(0,0,0,0,0, IDLE, 4'd15, "held_sat");
    step(1,0,0,0,1, LUB,  4'd15, "clr_and_stall");
    step(0,0,0,0,0, IDLE, 4'd0, "cleared");

    for (int i = 0; i < 20; i++) begin
      step(1,0,0,0,0, LUB, (i > 15) ? 4'd15 : 4'(i), "sat_run");
    end
    step(0,0,0,0,0, IDLE, 4'd15, "saturated");
    step(0,0,0,0,1, IDLE, 4'd15, "clr_only");
    step(0,0,0,0,0, IDLE, 4'd0, "clr_done");

    step(0,0,0,1,0, GO,   4'd0, "md_go3");
    step(0,0,0,0,0, BUSY, 4'd0, "md_busy_r1");
    step(0,0,0,0,0, BUSY, 4'd1, "md_busy_r2");

    // Asynchronous reset while busy: outputs drop before any clock edge.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    e.name = "reset_in_md";
    e.ctl  = IDLE;
    e.cnt  = 4'd0;
    q.push_back(e);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    step(0,0,0,0,0, IDLE, 4'd0, "post_reset");
    step(1,0,0,0,0, LUB,  4'd0, "post_reset_lu");
    step(0,0,0,0,0, IDLE, 4'd1, "post_reset_cnt");

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
